sample_pack_8: RTL and testbench
================================

SAMPLE_PACK_8 -- requirements
Module: sample_pack_8

Interface
REQ-001 Parameter: width, default 48, bit width of one complex sample (real and imaginary packed).
REQ-002 Parameter: width_group, default 384, width of one packed group; SHALL equal 8*width.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 clr  input  1  synchronous discard of the partial group and any pending group.
REQ-006 in_valid  input  1  in_data holds a sample.
REQ-007 in_ready  output  1  block accepts a sample this cycle.
REQ-008 in_data  input  width  incoming sample.
REQ-009 out_valid  output  1  out_data holds a complete group.
REQ-010 out_ready  input  1  consumer takes the group this cycle.
REQ-011 out_data  output  width_group  packed group; slot s occupies bits [(s+1)*width-1 : s*width].
REQ-012 fill_cnt  output  3  number of samples held in the partial group (0..7).

Function
REQ-013 A sample is accepted when in_valid && in_ready; a group is taken when out_valid && out_ready.
REQ-014 The k-th accepted sample of a group (k = 0..7) SHALL be written to slot k of the assembly register.
REQ-015 fill_cnt SHALL increment on each accept and wrap from 7 to 0 on the 8th accept.
REQ-016 States: FILL (assembling; in_ready=1) and HOLD (complete group waiting; in_ready=0).
REQ-017 On the 8th accept, if the output register is free (out_valid=0, or out_ready=1 in the same cycle), the complete group SHALL load into out_data with out_valid=1 in the next cycle, and the state SHALL stay FILL.
REQ-018 On the 8th accept with the output register occupied and not taken, the state SHALL go to HOLD.
REQ-019 In HOLD, the group SHALL move to the output register in the cycle the output register is freed, and the state SHALL return to FILL.
REQ-020 Latency from the 8th accept to out_valid=1 SHALL be 1 cycle when the output is free.
REQ-021 With out_ready held at 1, the block SHALL sustain 1 sample/cycle with no bubble across group boundaries.
REQ-022 out_valid SHALL clear after a take unless a new group loads in the same cycle; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 clr=1: fill_cnt <= 0, state <= FILL, any pending HOLD group dropped; the output register and out_valid are unaffected.
REQ-024 clr and an accept in the same cycle: clr wins and the sample is discarded.
REQ-025 Slots not yet written in a partial group are don't-care and are never visible on out_data.

Reset
REQ-026 rst_n=0 at a clock edge: out_valid=0, out_data=0, fill_cnt=0, state=FILL, assembly register=0.
REQ-027 in_ready SHALL read 0 while rst_n=0 and 1 in the first cycle after release.
REQ-028 Reset mid-group or in HOLD SHALL discard all partial and pending data.

Configuration
REQ-029 Macro PACK_BIT_REVERSE_EN, when defined: sample k SHALL be written to slot bitrev3(k), giving slot order 0,4,2,6,1,5,3,7.
REQ-030 Macro PACK_BIT_REVERSE_EN, when undefined: sample k SHALL be written to slot k (natural order); all handshake timing is identical in both builds.

Verification (sample k of group g carries value 16*g+k+1)
REQ-031 Reset, out_ready=1, 8 back-to-back samples -> out_valid=1 one cycle after the 8th, out_data slots 0..7 = 1..8, fill_cnt back to 0.
REQ-032 out_ready=0, 16 samples offered continuously -> group 0 in the output register, group 1 in HOLD, in_ready=0 after the 16th accept; raise out_ready -> groups 0 then 1 on consecutive cycles, then in_ready=1.
REQ-033 3 samples accepted, then clr pulsed together with a 4th valid sample -> fill_cnt=0 and the sample dropped; the next 8 samples form a group with slots = those 8 values only.
REQ-034 Streaming 4 groups with out_ready=1 -> in_ready constantly 1, one out_valid pulse every 8 cycles, no data lost.
REQ-035 PACK_BIT_REVERSE_EN defined, samples 1..8 -> out_data slots 0..7 = 1,5,3,7,2,6,4,8.
REQ-036 rst_n asserted after 5 samples, with a group pending -> all outputs at reset values next cycle; the following 8 samples form a clean group.

Source files
------------

// File: rtl/sample_pack_8.sv
// sample_pack_8
// Packs eight consecutive complex samples into one wide group. A group
// completing while the output register is occupied waits in HOLD, and
// input is stalled until it drains.
// Build macro PACK_BIT_REVERSE_EN: when defined, sample k of a group is
// written to slot bitrev3(k) instead of slot k. Handshake timing is the
// same in both builds.
module sample_pack_8 #(
    parameter int width       = 48,
    parameter int width_group = 384
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [width-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [width_group-1:0] out_data,
    output logic [2:0]             fill_cnt
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             fill_q, fill_d;
    logic [width_group-1:0] asm_q, asm_d;
    logic [width_group-1:0] out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;

    logic                   accept;
    logic                   out_free;
    logic [2:0]             slot;
    logic [width_group-1:0] group_w;

    assign in_ready  = rst_n && (state_q == FILL);
    assign accept    = in_valid && in_ready;
    assign out_free  = !out_valid_q || out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign fill_cnt  = fill_q;

    // Map the running sample index of the group onto its slot position
    always_comb begin
`ifdef PACK_BIT_REVERSE_EN
        slot = {fill_q[0], fill_q[1], fill_q[2]};
`else
        slot = fill_q;
`endif
    end

    // Assembly register with the incoming sample dropped into its slot;
    // on the eighth accept this is the complete group
    always_comb begin
        group_w = asm_q;
        for (int s = 0; s < 8; s++) begin
            if (slot == 3'(s)) begin
                group_w[s*width +: width] = in_data;
            end
        end
    end

    // Next-state: take clears the output, clr discards partial/pending work,
    // otherwise assemble in FILL or drain the pending group from HOLD.
    // The completed group stays in the assembly register while in HOLD.
    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        asm_d       = asm_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (clr) begin
            fill_d  = 3'd0;
            state_d = FILL;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        asm_d  = group_w;
                        fill_d = fill_q + 3'd1;
                        if (fill_q == 3'd7) begin
                            if (out_free) begin
                                out_data_d  = group_w;
                                out_valid_d = 1'b1;
                            end else begin
                                state_d = HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (out_free) begin
                        out_data_d  = asm_q;
                        out_valid_d = 1'b1;
                        state_d     = FILL;
                    end
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FILL;
            fill_q      <= 3'd0;
            asm_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            asm_q       <= asm_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_sample_pack_8.sv
// tb_sample_pack_8
// Randomised and directed stimulus for sample_pack_8, checked against a
// queue-based behavioural model of the packer. Honours PACK_BIT_REVERSE_EN.
module tb_sample_pack_8;

    localparam int W  = 48;
    localparam int WG = 384;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [WG-1:0] out_data;
    logic [2:0]    fill_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef PACK_BIT_REVERSE_EN
    int slot_val [8] = '{1, 5, 3, 7, 2, 6, 4, 8};
`else
    int slot_val [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
`endif

    // Behavioural model state
    logic [W-1:0]  m_part [$];
    logic          m_hold_valid;
    logic [WG-1:0] m_hold_data;
    logic          m_out_valid;
    logic [WG-1:0] m_out_data;

    sample_pack_8 #(.width(W), .width_group(WG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .fill_cnt  (fill_cnt)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int slot_of(input int k);
`ifdef PACK_BIT_REVERSE_EN
        return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
`else
        return k;
`endif
    endfunction

    function automatic logic [W-1:0] rand_sample();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    // Apply the rules of the packer to the currently driven inputs
    task automatic model_step();
        logic          acc;
        logic          free;
        logic [WG-1:0] g;
        if (!rst_n) begin
            m_part.delete();
            m_hold_valid = 1'b0;
            m_hold_data  = '0;
            m_out_valid  = 1'b0;
            m_out_data   = '0;
            return;
        end
        acc  = in_valid && !m_hold_valid;
        free = !m_out_valid || out_ready;
        if (m_out_valid && out_ready) m_out_valid = 1'b0;
        if (clr) begin
            m_part.delete();
            m_hold_valid = 1'b0;
        end else if (m_hold_valid) begin
            if (free) begin
                m_out_data   = m_hold_data;
                m_out_valid  = 1'b1;
                m_hold_valid = 1'b0;
            end
        end else if (acc) begin
            m_part.push_back(in_data);
            if (m_part.size() == 8) begin
                g = '0;
                for (int k = 0; k < 8; k++) g[slot_of(k)*W +: W] = m_part[k];
                m_part.delete();
                if (free) begin
                    m_out_data  = g;
                    m_out_valid = 1'b1;
                end else begin
                    m_hold_data  = g;
                    m_hold_valid = 1'b1;
                end
            end
        end
    endtask

    // Drive one clock cycle of inputs, advance the model, sample after the edge
    task automatic cycle(input logic r, input logic c, input logic iv,
                         input logic [W-1:0] d, input logic orr);
        rst_n     = r;
        clr       = c;
        in_valid  = iv;
        in_data   = d;
        out_ready = orr;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, W'(5), 1'b1);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset.out_valid got %0b want 0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_fail++; $display("[TB] FAIL reset.out_data got %h want 0", out_data); end
        n_cmp++; if (fill_cnt !== 3'd0) begin n_fail++; $display("[TB] FAIL reset.fill_cnt got %0d want 0", fill_cnt); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset.in_ready_low got %0b want 0", in_ready); end
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset.in_ready_release got %0b want 1", in_ready); end
    endtask

    task automatic test_basic();
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, 1'b0, 1'b1, W'(k + 1), 1'b1);
            n_cmp++; if (fill_cnt !== 3'((k + 1) % 8)) begin n_fail++; $display("[TB] FAIL basic.fill_cnt got %0d want %0d", fill_cnt, (k + 1) % 8); end
            n_cmp++; if (out_valid !== (k == 7)) begin n_fail++; $display("[TB] FAIL basic.out_valid got %0b want %0b", out_valid, k == 7); end
        end
        for (int s = 0; s < 8; s++) begin
            n_cmp++; if (out_data[s*W +: W] !== W'(slot_val[s])) begin n_fail++; $display("[TB] FAIL basic.slot%0d got %0d want %0d", s, out_data[s*W +: W], slot_val[s]); end
        end
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic.out_valid_clear got %0b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp.in_ready_fill got %0b want 1", in_ready); end
            cycle(1'b1, 1'b0, 1'b1, W'(16 * (i / 8) + (i % 8) + 1), 1'b0);
        end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp.in_ready_hold got %0b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b1 || out_data !== m_out_data) begin n_fail++; $display("[TB] FAIL bp.group0 got %0b/%h want 1/%h", out_valid, out_data, m_out_data); end
        n_cmp++; if (out_data[W-1:0] !== W'(1)) begin n_fail++; $display("[TB] FAIL bp.group0_slot0 got %0d want 1", out_data[W-1:0]); end
        cycle(1'b1, 1'b0, 1'b1, W'(99), 1'b0);
        n_cmp++; if (fill_cnt !== 3'd0 || out_data[W-1:0] !== W'(1)) begin n_fail++; $display("[TB] FAIL bp.stall got fill %0d slot0 %0d want 0/1", fill_cnt, out_data[W-1:0]); end
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== m_out_data) begin n_fail++; $display("[TB] FAIL bp.group1 got %0b/%h want 1/%h", out_valid, out_data, m_out_data); end
        n_cmp++; if (out_data[W-1:0] !== W'(17)) begin n_fail++; $display("[TB] FAIL bp.group1_slot0 got %0d want 17", out_data[W-1:0]); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp.in_ready_after got %0b want 1", in_ready); end
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp.drained got %0b want 0", out_valid); end
    endtask

    task automatic test_clear();
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b1, W'(100 + k), 1'b1);
        n_cmp++; if (fill_cnt !== 3'd3) begin n_fail++; $display("[TB] FAIL clear.fill_before got %0d want 3", fill_cnt); end
        cycle(1'b1, 1'b1, 1'b1, W'(999), 1'b1);
        n_cmp++; if (fill_cnt !== 3'd0) begin n_fail++; $display("[TB] FAIL clear.fill_after got %0d want 0", fill_cnt); end
        for (int k = 0; k < 8; k++) cycle(1'b1, 1'b0, 1'b1, W'(16 + k + 1), 1'b1);
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL clear.out_valid got %0b want 1", out_valid); end
        for (int s = 0; s < 8; s++) begin
            n_cmp++; if (out_data[s*W +: W] !== W'(16 + slot_val[s])) begin n_fail++; $display("[TB] FAIL clear.slot%0d got %0d want %0d", s, out_data[s*W +: W], 16 + slot_val[s]); end
        end
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 32; i++) begin
            n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b.in_ready cycle %0d got %0b want 1", i, in_ready); end
            cycle(1'b1, 1'b0, 1'b1, W'(16 * (i / 8) + (i % 8) + 1), 1'b1);
            n_cmp++; if (out_valid !== ((i % 8) == 7)) begin n_fail++; $display("[TB] FAIL b2b.out_valid cycle %0d got %0b want %0b", i, out_valid, (i % 8) == 7); end
            if (out_valid) begin
                pulses++;
                n_cmp++; if (out_data !== m_out_data) begin n_fail++; $display("[TB] FAIL b2b.data got %h want %h", out_data, m_out_data); end
            end
        end
        n_cmp++; if (pulses != 4) begin n_fail++; $display("[TB] FAIL b2b.pulses got %0d want 4", pulses); end
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 8; k++) cycle(1'b1, 1'b0, 1'b1, W'(200 + k), 1'b0);
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 1'b1, W'(300 + k), 1'b0);
        n_cmp++; if (out_valid !== 1'b1 || fill_cnt !== 3'd5) begin n_fail++; $display("[TB] FAIL rmid.pre got %0b/%0d want 1/5", out_valid, fill_cnt); end
        cycle(1'b0, 1'b0, 1'b1, W'(7), 1'b0);
        n_cmp++; if (out_valid !== 1'b0 || out_data !== '0) begin n_fail++; $display("[TB] FAIL rmid.out got %0b/%h want 0/0", out_valid, out_data); end
        n_cmp++; if (fill_cnt !== 3'd0 || in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid.fill_ready got %0d/%0b want 0/0", fill_cnt, in_ready); end
        for (int k = 0; k < 8; k++) cycle(1'b1, 1'b0, 1'b1, W'(k + 1), 1'b1);
        for (int s = 0; s < 8; s++) begin
            n_cmp++; if (out_data[s*W +: W] !== W'(slot_val[s])) begin n_fail++; $display("[TB] FAIL rmid.slot%0d got %0d want %0d", s, out_data[s*W +: W], slot_val[s]); end
        end
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic test_random();
        logic r, c, iv, orr;
        for (int i = 0; i < 600; i++) begin
            n_cmp++; if (in_ready !== (rst_n && !m_hold_valid)) begin n_fail++; $display("[TB] FAIL rand.in_ready cycle %0d got %0b want %0b", i, in_ready, rst_n && !m_hold_valid); end
            r   = ($urandom_range(0, 63) != 0);
            c   = ($urandom_range(0, 15) == 0);
            iv  = ($urandom_range(0, 3) != 0);
            orr = ($urandom_range(0, 1) == 1);
            cycle(r, c, iv, rand_sample(), orr);
            n_cmp++; if (out_valid !== m_out_valid) begin n_fail++; $display("[TB] FAIL rand.out_valid cycle %0d got %0b want %0b", i, out_valid, m_out_valid); end
            n_cmp++; if (fill_cnt !== 3'(m_part.size())) begin n_fail++; $display("[TB] FAIL rand.fill_cnt cycle %0d got %0d want %0d", i, fill_cnt, m_part.size()); end
            if (m_out_valid) begin
                n_cmp++; if (out_data !== m_out_data) begin n_fail++; $display("[TB] FAIL rand.out_data cycle %0d got %h want %h", i, out_data, m_out_data); end
            end
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        m_hold_valid = 1'b0;
        m_hold_data  = '0;
        m_out_valid  = 1'b0;
        m_out_data   = '0;
        $display("[TB] start");
        test_reset();
        test_basic();
        test_backpressure();
        test_clear();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
